// File: rtl/hpm_window_seq_if.sv
// Detector-side channel of the HPM window sequencer: delta beats over valid/ready
// plus the detector's end-of-window done strobe.
interface hpm_window_seq_if #(
  parameter int NUM_CNT = 32,
  parameter int CNT_W   = 64
);
  localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  logic             det_valid_o;
  logic             det_ready_i;
  logic [IDX_W-1:0] det_idx_o;
  logic [CNT_W-1:0] det_delta_o;
  logic             det_last_o;
  logic             det_done_i;

  modport master (
    output det_valid_o, det_idx_o, det_delta_o, det_last_o,
    input  det_ready_i, det_done_i
  );

  modport slave (
    input  det_valid_o, det_idx_o, det_delta_o, det_last_o,
    output det_ready_i, det_done_i
  );
endinterface

// File: rtl/hpm_window_seq.sv
// HPM measurement-window sequencer: snapshots counters on CSR start/stop markers and
// streams masked per-counter deltas to the detector. Optional timeout: HPMSEQ_TIMEOUT_EN.
module hpm_window_seq #(
  parameter int          NUM_CNT   = 32,
  parameter int          CNT_W     = 64,
  parameter logic [11:0] MARK_ADDR = 12'h320,
  parameter logic [31:0] START_VAL = 32'h0000_0000,
  parameter logic [31:0] STOP_VAL  = 32'hFFFF_FFFF,
  parameter int          WIN_MAX   = 1_000_000
) (
  input  logic                            clk_h,
  input  logic                            rst_h,
  input  logic                            csr_we,
  input  logic [11:0]                     csr_add,
  input  logic [31:0]                     csr_data,
  input  logic [NUM_CNT-1:0][CNT_W-1:0]   hpm_i,
  input  logic [NUM_CNT-1:0]              cnt_mask_i,
  hpm_window_seq_if.master                det,
  output logic                            busy_o,
  output logic [31:0]                     win_cycles_o,
  output logic                            overrun_o,
  output logic                            timeout_o
);
  localparam int          IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STREAM, ST_WAIT_DONE} state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   base_r  [NUM_CNT];
  logic [CNT_W-1:0]   delta_r [NUM_CNT];
  logic [NUM_CNT-1:0] rem_r, rem_s, rem_after_s;
  logic [31:0]        win_cnt_r, win_cnt_s, win_inc_s;
  logic [31:0]        win_cycles_r, win_cycles_s;
  logic               valid_r, valid_s, last_r, last_s;
  logic [IDX_W-1:0]   idx_r, idx_s, next_idx_s, first_idx_s;
  logic [CNT_W-1:0]   dout_r, dout_s, first_delta_s;
  logic               busy_r, overrun_r, overrun_s, timeout_r, timeout_s;
  logic               start_s, stop_s, timeout_hit_s, cap_base_s, cap_delta_s;

  function automatic logic [IDX_W-1:0] lsb_idx(input logic [NUM_CNT-1:0] m);
    lsb_idx = {IDX_W{1'b0}};
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      lsb_idx = m[i] ? IDX_W'(i) : lsb_idx;
    end
  endfunction

  function automatic logic at_most_one(input logic [NUM_CNT-1:0] m);
    return (m & (m - NUM_CNT'(1))) == {NUM_CNT{1'b0}};
  endfunction

  assign start_s = csr_we && (csr_add == MARK_ADDR) && (csr_data == START_VAL);
  assign stop_s  = csr_we && (csr_add == MARK_ADDR) && (csr_data == STOP_VAL);

  // rem_r holds the not-yet-sent mask bits; clearing its lowest bit yields the next beat
  assign rem_after_s   = rem_r & (rem_r - NUM_CNT'(1));
  assign next_idx_s    = lsb_idx(rem_after_s);
  assign first_idx_s   = lsb_idx(cnt_mask_i);
  assign first_delta_s = hpm_i[first_idx_s] - base_r[first_idx_s];
  assign win_inc_s     = (win_cnt_r == CNT_MAX) ? CNT_MAX : win_cnt_r + 32'd1;

`ifdef HPMSEQ_TIMEOUT_EN
  assign timeout_hit_s = (win_cnt_r == 32'(WIN_MAX - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    rem_s        = rem_r;
    win_cnt_s    = win_cnt_r;
    win_cycles_s = win_cycles_r;
    valid_s      = valid_r;
    last_s       = last_r;
    idx_s        = idx_r;
    dout_s       = dout_r;
    timeout_s    = timeout_r;
    cap_base_s   = 1'b0;
    cap_delta_s  = 1'b0;
    overrun_s    = overrun_r |
                   (start_s && ((state_r == ST_STREAM) || (state_r == ST_WAIT_DONE)));
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s    = ST_RUN;
          cap_base_s = 1'b1;
          win_cnt_s  = 32'd0;
          timeout_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        win_cnt_s = win_inc_s;
        if (stop_s || timeout_hit_s) begin
          cap_delta_s  = 1'b1;
          rem_s        = cnt_mask_i;
          win_cycles_s = win_inc_s;
          timeout_s    = timeout_hit_s && !stop_s;
          if (cnt_mask_i != {NUM_CNT{1'b0}}) begin
            state_s = ST_STREAM;
            valid_s = 1'b1;
            idx_s   = first_idx_s;
            dout_s  = first_delta_s;
            last_s  = at_most_one(cnt_mask_i);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STREAM: begin
        if (valid_r && det.det_ready_i) begin
          if (last_r) begin
            state_s = ST_WAIT_DONE;
            valid_s = 1'b0;
            last_s  = 1'b0;
            rem_s   = {NUM_CNT{1'b0}};
          end else begin
            rem_s  = rem_after_s;
            idx_s  = next_idx_s;
            dout_s = delta_r[next_idx_s];
            last_s = at_most_one(rem_after_s);
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_WAIT_DONE: begin
        if (det.det_done_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state_r      <= ST_IDLE;
      rem_r        <= {NUM_CNT{1'b0}};
      win_cnt_r    <= 32'd0;
      win_cycles_r <= 32'd0;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
      dout_r       <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      rem_r        <= rem_s;
      win_cnt_r    <= win_cnt_s;
      win_cycles_r <= win_cycles_s;
      valid_r      <= valid_s;
      last_r       <= last_s;
      idx_r        <= idx_s;
      dout_r       <= dout_s;
      busy_r       <= (state_s != ST_IDLE);
      overrun_r    <= overrun_s;
      timeout_r    <= timeout_s;
    end
  end

  // Counter snapshots at window open and close
  always_ff @(posedge clk_h) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst_h) begin
        base_r[i]  <= {CNT_W{1'b0}};
        delta_r[i] <= {CNT_W{1'b0}};
      end else begin
        if (cap_base_s) base_r[i] <= hpm_i[i];
        if (cap_delta_s) delta_r[i] <= hpm_i[i] - base_r[i];
      end
    end
  end

  assign det.det_valid_o = valid_r;
  assign det.det_idx_o   = idx_r;
  assign det.det_delta_o = dout_r;
  assign det.det_last_o  = last_r;
  assign busy_o          = busy_r;
  assign win_cycles_o    = win_cycles_r;
  assign overrun_o       = overrun_r;
  assign timeout_o       = timeout_r;
endmodule
